// File: rtl/cm3_gpio_pkg.sv
// Shared constants for the CM3 GPIO bank: register byte offsets, AHB transfer
// encodings and the byte-lane mask helper used when capturing an address phase.
package cm3_gpio_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [7:0] OFF_DATA_IN    = 8'h00;
  localparam logic [7:0] OFF_DATA_OUT   = 8'h04;
  localparam logic [7:0] OFF_OUT_EN     = 8'h08;
  localparam logic [7:0] OFF_OUT_SET    = 8'h0C;
  localparam logic [7:0] OFF_OUT_CLR    = 8'h10;
  localparam logic [7:0] OFF_IRQ_EN     = 8'h14;
  localparam logic [7:0] OFF_IRQ_TYPE   = 8'h18;
  localparam logic [7:0] OFF_IRQ_POL    = 8'h1C;
  localparam logic [7:0] OFF_IRQ_STATUS = 8'h20;

  // Byte-expanded write mask for a transfer of the given HSIZE at HADDR[1:0].
  function automatic logic [31:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0]  lanes;
    logic [31:0] m;
    case (size)
      3'd0:    lanes = 4'b0001 << addr;
      3'd1:    lanes = addr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{lanes[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/cm3_gpio_sync.sv
// Pad-input synchroniser with a one-cycle-delayed copy for edge detection.
// Edges are held off until the chain has flushed its reset value.
module cm3_gpio_sync
  import cm3_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_async,
  output logic [WIDTH-1:0] d_sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] stage_reg [SYNC_STAGES];
  logic [WIDTH-1:0] prev_reg;
  logic [2:0]       warm_reg;
  logic             warm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_reg[i] <= '0;
      prev_reg <= '0;
      warm_reg <= '0;
    end else begin
      stage_reg[0] <= d_async;
      for (int i = 1; i < SYNC_STAGES; i++) stage_reg[i] <= stage_reg[i-1];
      prev_reg <= stage_reg[SYNC_STAGES-1];
      if (warm_reg != WARM_CYCLES) warm_reg <= warm_reg + 3'd1;
    end
  end

  assign warm   = (warm_reg == WARM_CYCLES);
  assign d_sync = stage_reg[SYNC_STAGES-1];
  assign rise   = {WIDTH{warm}} & d_sync & ~prev_reg;
  assign fall   = {WIDTH{warm}} & ~d_sync & prev_reg;

endmodule

// File: rtl/cm3_gpio_irq.sv
// AHB-Lite GPIO bank with per-pin edge/level interrupts, atomic set/clear of
// DATA_OUT and registered IRQ lines folded modulo NUM_IRQ.
module cm3_gpio_irq
  import cm3_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_IRQ     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic               CLK_CM3,
  input  logic               SYS_RSTN,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADYMUX,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  output logic               HRESP,
  input  logic [WIDTH-1:0]   GPIO_IN,
  output logic [WIDTH-1:0]   GPIO_OUT,
  output logic [WIDTH-1:0]   GPIO_OUT_EN,
  output logic [NUM_IRQ-1:0] IRQ
);

  logic               accept;
  logic               wr_pend_reg;
  logic [ADDR_W-1:0]  waddr_reg, raddr;
  logic [31:0]        wmask_reg, wbits32, rd_val, hrdata_reg;
  logic [WIDTH-1:0]   wbits, wmask_w, w1c, d_sync, rise, fall, ev_edge, ev_level;
  logic [WIDTH-1:0]   data_out_reg, out_en_reg, irq_en_reg, irq_type_reg, irq_pol_reg, status_reg;
  logic [WIDTH-1:0]   data_out_next, out_en_next, irq_en_next, irq_type_next, irq_pol_next, status_next;
  logic [NUM_IRQ-1:0] irq_reg, irq_next;
  logic               unused_haddr;

  assign unused_haddr = ^HADDR[31:ADDR_W];
  assign accept  = HSEL & HREADYMUX & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign raddr   = {HADDR[ADDR_W-1:2], 2'b00};
  assign wbits32 = HWDATA & wmask_reg;
  assign wbits   = wbits32[WIDTH-1:0];
  assign wmask_w = wmask_reg[WIDTH-1:0];

  cm3_gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (CLK_CM3),
    .rst_n   (SYS_RSTN),
    .d_async (GPIO_IN),
    .d_sync  (d_sync),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    data_out_next = data_out_reg;
    out_en_next   = out_en_reg;
    irq_en_next   = irq_en_reg;
    irq_type_next = irq_type_reg;
    irq_pol_next  = irq_pol_reg;
    w1c           = '0;
    if (wr_pend_reg) begin
      case (waddr_reg)
        ADDR_W'(OFF_DATA_OUT):   data_out_next = (data_out_reg & ~wmask_w) | wbits;
        ADDR_W'(OFF_OUT_EN):     out_en_next   = (out_en_reg & ~wmask_w) | wbits;
        ADDR_W'(OFF_OUT_SET):    data_out_next = data_out_reg | wbits;
        ADDR_W'(OFF_OUT_CLR):    data_out_next = data_out_reg & ~wbits;
        ADDR_W'(OFF_IRQ_EN):     irq_en_next   = (irq_en_reg & ~wmask_w) | wbits;
        ADDR_W'(OFF_IRQ_TYPE):   irq_type_next = (irq_type_reg & ~wmask_w) | wbits;
        ADDR_W'(OFF_IRQ_POL):    irq_pol_next  = (irq_pol_reg & ~wmask_w) | wbits;
        ADDR_W'(OFF_IRQ_STATUS): w1c           = wbits;
        default: ;
      endcase
    end
    ev_edge  = irq_type_reg & ((irq_pol_reg & rise) | (~irq_pol_reg & fall));
    ev_level = ~irq_type_reg & ~(d_sync ^ irq_pol_reg);
    // Edge events beat a same-cycle W1C; a held level re-asserts one cycle after it.
    status_next = (status_reg & ~w1c) | (irq_en_reg & ev_edge) | (irq_en_reg & ev_level & ~w1c);
  end

  // Reads see post-edge register values, which forwards a same-edge write.
  always_comb begin
    rd_val = '0;
    case (raddr)
      ADDR_W'(OFF_DATA_IN):    rd_val[WIDTH-1:0] = d_sync;
      ADDR_W'(OFF_DATA_OUT):   rd_val[WIDTH-1:0] = data_out_next;
      ADDR_W'(OFF_OUT_EN):     rd_val[WIDTH-1:0] = out_en_next;
      ADDR_W'(OFF_IRQ_EN):     rd_val[WIDTH-1:0] = irq_en_next;
      ADDR_W'(OFF_IRQ_TYPE):   rd_val[WIDTH-1:0] = irq_type_next;
      ADDR_W'(OFF_IRQ_POL):    rd_val[WIDTH-1:0] = irq_pol_next;
      ADDR_W'(OFF_IRQ_STATUS): rd_val[WIDTH-1:0] = status_next;
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irq
    logic [WIDTH-1:0] sel;
    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_pin
      assign sel[gj] = ((gj % NUM_IRQ) == gi);
    end
    assign irq_next[gi] = |(status_reg & sel);
  end

  always_ff @(posedge CLK_CM3 or negedge SYS_RSTN) begin
    if (!SYS_RSTN) begin
      wr_pend_reg  <= 1'b0;
      waddr_reg    <= '0;
      wmask_reg    <= '0;
      hrdata_reg   <= '0;
      data_out_reg <= '0;
      out_en_reg   <= '0;
      irq_en_reg   <= '0;
      irq_type_reg <= '0;
      irq_pol_reg  <= '0;
      status_reg   <= '0;
      irq_reg      <= '0;
    end else begin
      wr_pend_reg  <= accept & HWRITE;
      if (accept & HWRITE) begin
        waddr_reg <= raddr;
        wmask_reg <= lane_mask(HSIZE, HADDR[1:0]);
      end
      if (accept & ~HWRITE) hrdata_reg <= rd_val;
      data_out_reg <= data_out_next;
      out_en_reg   <= out_en_next;
      irq_en_reg   <= irq_en_next;
      irq_type_reg <= irq_type_next;
      irq_pol_reg  <= irq_pol_next;
      status_reg   <= status_next;
      irq_reg      <= irq_next;
    end
  end

  assign HRDATA      = hrdata_reg;
  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign GPIO_OUT    = data_out_reg;
  assign GPIO_OUT_EN = out_en_reg;
  assign IRQ         = irq_reg;

endmodule
